// File: rtl/reset_sequencer_pkg.sv
// Shared definitions for the reset sequencer: FSM state encodings and
// reset-cause codes reported on rst_cause.
package reset_sequencer_pkg;

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_HOLD   = 3'd1,
    S_PERIPH = 3'd2,
    S_RUN    = 3'd3,
    S_SOFT   = 3'd4
  } state_t;

  localparam logic [1:0] CAUSE_POR  = 2'b01;
  localparam logic [1:0] CAUSE_SOFT = 2'b10;

endpackage

// File: rtl/reset_sequencer_sync.sv
// Async-assert / sync-deassert reset synchroniser.
// Ports:
//   clk      in   system clock
//   rst_n    in   async active-low reset (porb)
//   rst_sync out  high on the SYNC_STAGES-th rising edge after rst_n rises,
//                 cleared immediately while rst_n is low
module reset_sequencer_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic rst_sync
);

  logic [SYNC_STAGES-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign rst_sync = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Reset sequencer: synchronises porb release, holds reset for HOLD_CYCLES,
// releases periph_rst_n, then core_rst_n STAGE_GAP cycles later. Handles a
// software warm reset from S_RUN and reports the last reset cause.
// Ports:
//   clk           in   system clock
//   rst_n         in   async active-low reset from the POR cell
//   soft_rst_req  in   warm reset request, sampled only in S_RUN
//   periph_rst_n  out  registered active-low peripheral reset
//   core_rst_n    out  registered active-low CPU core reset
//   rst_done      out  high while in S_RUN (both resets released)
//   rst_cause     out  01 = POR, 10 = soft; sticky until next reset event
//
// state    | meaning
// S_RESET  | waiting for synchronised porb release, all resets low
// S_HOLD   | counting HOLD_CYCLES with all resets low
// S_PERIPH | peripherals released, core held for STAGE_GAP cycles
// S_RUN    | both resets released, soft request accepted here
// S_SOFT   | warm reset, both resets low for SOFT_CYCLES
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 16,
  parameter int STAGE_GAP   = 4,
  parameter int SOFT_CYCLES = 8,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       soft_rst_req,
  output logic       periph_rst_n,
  output logic       core_rst_n,
  output logic       rst_done,
  output logic [1:0] rst_cause
);

  localparam int CNT_MAX = (1 << CNT_W) - 1;

  if (SYNC_STAGES < 2) begin : g_chk_sync
    $error("SYNC_STAGES must be at least 2");
  end
  if (HOLD_CYCLES < 1 || HOLD_CYCLES > CNT_MAX) begin : g_chk_hold
    $error("HOLD_CYCLES out of range");
  end
  if (STAGE_GAP < 1 || STAGE_GAP > CNT_MAX) begin : g_chk_gap
    $error("STAGE_GAP out of range");
  end
  if (SOFT_CYCLES < 1 || SOFT_CYCLES > CNT_MAX) begin : g_chk_soft
    $error("SOFT_CYCLES out of range");
  end

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);
  localparam logic [CNT_W-1:0] SOFT_LAST = CNT_W'(SOFT_CYCLES - 1);

  logic w_rst_sync;

  reset_sequencer_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .rst_sync (w_rst_sync)
  );

  state_t           r_state, w_state;
  logic [CNT_W-1:0] r_cnt, w_cnt;
  logic             r_periph, w_periph;
  logic             r_core, w_core;
  logic             r_done, w_done;
  logic [1:0]       r_cause, w_cause;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_RESET;
      r_cnt    <= '0;
      r_periph <= 1'b0;
      r_core   <= 1'b0;
      r_done   <= 1'b0;
      r_cause  <= CAUSE_POR;
    end else begin
      r_state  <= w_state;
      r_cnt    <= w_cnt;
      r_periph <= w_periph;
      r_core   <= w_core;
      r_done   <= w_done;
      r_cause  <= w_cause;
    end
  end

  // Counter is cleared on every transition and compared for equality, so it
  // never needs to wrap.
  always_comb begin
    w_state  = r_state;
    w_cnt    = r_cnt + CNT_W'(1);
    w_periph = r_periph;
    w_core   = r_core;
    w_done   = r_done;
    w_cause  = r_cause;
    case (r_state)
      S_RESET: begin
        w_cnt    = '0;
        w_periph = 1'b0;
        w_core   = 1'b0;
        w_done   = 1'b0;
        if (w_rst_sync) begin
          w_state = S_HOLD;
        end
      end
      S_HOLD: begin
        if (r_cnt == HOLD_LAST) begin
          w_state  = S_PERIPH;
          w_periph = 1'b1;
          w_cnt    = '0;
        end
      end
      S_PERIPH: begin
        if (r_cnt == GAP_LAST) begin
          w_state = S_RUN;
          w_core  = 1'b1;
          w_done  = 1'b1;
          w_cnt   = '0;
        end
      end
      S_RUN: begin
        w_cnt = '0;
        if (soft_rst_req) begin
          w_state  = S_SOFT;
          w_periph = 1'b0;
          w_core   = 1'b0;
          w_done   = 1'b0;
          w_cause  = CAUSE_SOFT;
        end
      end
      S_SOFT: begin
        if (r_cnt == SOFT_LAST) begin
          w_state  = S_PERIPH;
          w_periph = 1'b1;
          w_cnt    = '0;
        end
      end
      default: begin
        w_state  = S_RESET;
        w_cnt    = '0;
        w_periph = 1'b0;
        w_core   = 1'b0;
        w_done   = 1'b0;
      end
    endcase
  end

  assign periph_rst_n = r_periph;
  assign core_rst_n   = r_core;
  assign rst_done     = r_done;
  assign rst_cause    = r_cause;

endmodule

// File: tb/tb_reset_sequencer.sv
module tb_reset_sequencer;
  import reset_sequencer_pkg::*;

  localparam int SYNC   = 2;
  localparam int HOLD   = 16;
  localparam int GAP    = 4;
  localparam int SOFT   = 8;
  localparam int T_PER  = SYNC + 1 + HOLD;
  localparam int T_CORE = T_PER + GAP;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       soft_rst_req = 1'b0;
  logic       periph_rst_n, core_rst_n, rst_done;
  logic [1:0] rst_cause;

  int n_checks = 0;
  int n_fail   = 0;

  reset_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .soft_rst_req (soft_rst_req),
    .periph_rst_n (periph_rst_n),
    .core_rst_n   (core_rst_n),
    .rst_done     (rst_done),
    .rst_cause    (rst_cause)
  );

  always #5 clk = ~clk;

  // Behavioural model: edges counted since rst_n release, plus the edge
  // at which the most recent accepted soft request was sampled.
  int edge_n     = 0;
  bit soft_valid = 1'b0;
  int soft_k     = 0;
  bit m_acc;

  function automatic logic m_periph();
    if (!rst_n) return 1'b0;
    return soft_valid ? (edge_n >= soft_k + SOFT) : (edge_n >= T_PER);
  endfunction

  function automatic logic m_core();
    if (!rst_n) return 1'b0;
    return soft_valid ? (edge_n >= soft_k + SOFT + GAP) : (edge_n >= T_CORE);
  endfunction

  function automatic logic [1:0] m_cause();
    return soft_valid ? 2'b10 : 2'b01;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_n     = 0;
      soft_valid = 1'b0;
    end else begin
      m_acc  = m_core() && soft_rst_req;
      edge_n = edge_n + 1;
      if (m_acc) begin
        soft_valid = 1'b1;
        soft_k     = edge_n;
      end
    end
  end

  task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #2;
    check("model_periph", periph_rst_n, m_periph());
    check("model_core", core_rst_n, m_core());
    check("model_done", rst_done, m_core());
    check("model_cause", rst_cause, m_cause());
    check("inv_core_le_periph", core_rst_n & ~periph_rst_n, 2'b00);
    check("inv_done_state", rst_done, dut.r_state == S_RUN);
  end

  // Starts at the cycle edge 1 follows; optionally pulses soft_rst_req at
  // one edge (ignored because the core is still held).
  task automatic por_sequence(input int pulse_edge);
    for (int e = 1; e <= T_CORE; e++) begin
      soft_rst_req = (e == pulse_edge);
      @(posedge clk);
      #2;
      if (e == T_PER - 1) check("por_periph_before", periph_rst_n, 1'b0);
      if (e == T_PER) begin
        check("por_periph_rise", periph_rst_n, 1'b1);
        check("por_core_low", core_rst_n, 1'b0);
      end
      if (e == T_CORE - 1) check("por_core_before", core_rst_n, 1'b0);
      if (e == T_CORE) begin
        check("por_core_rise", core_rst_n, 1'b1);
        check("por_done", rst_done, 1'b1);
        check("por_cause", rst_cause, 2'b01);
      end
      @(negedge clk);
    end
    soft_rst_req = 1'b0;
  endtask

  task automatic por_from_low();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Called at a negedge while in S_RUN.
  task automatic soft_sequence(input int pulse_off);
    soft_rst_req = 1'b1;
    @(posedge clk);
    #2;
    check("soft_periph_low", periph_rst_n, 1'b0);
    check("soft_core_low", core_rst_n, 1'b0);
    check("soft_done_low", rst_done, 1'b0);
    check("soft_cause", rst_cause, 2'b10);
    @(negedge clk);
    for (int e = 1; e <= SOFT + GAP; e++) begin
      soft_rst_req = (e == pulse_off);
      @(posedge clk);
      #2;
      if (e == SOFT - 1) check("soft_periph_before", periph_rst_n, 1'b0);
      if (e == SOFT) begin
        check("soft_periph_rise", periph_rst_n, 1'b1);
        check("soft_core_still_low", core_rst_n, 1'b0);
      end
      if (e == SOFT + GAP - 1) check("soft_core_before", core_rst_n, 1'b0);
      if (e == SOFT + GAP) begin
        check("soft_core_rise", core_rst_n, 1'b1);
        check("soft_cause_sticky", rst_cause, 2'b10);
      end
      @(negedge clk);
    end
    soft_rst_req = 1'b0;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1 check("reset_periph", periph_rst_n, 1'b0);
    check("reset_core", core_rst_n, 1'b0);
    check("reset_done", rst_done, 1'b0);
    check("reset_cause", rst_cause, 2'b01);

    // POR with defaults
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    por_sequence(0);

    // Soft reset
    repeat (3) @(negedge clk);
    soft_sequence(0);

    // Sub-cycle glitch in S_RUN
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("glitch_periph", periph_rst_n, 1'b0);
    check("glitch_core", core_rst_n, 1'b0);
    check("glitch_done", rst_done, 1'b0);
    check("glitch_cause", rst_cause, 2'b01);
    #2 rst_n = 1'b1;
    por_sequence(0);

    // Ignored requests during S_HOLD and S_SOFT
    por_from_low();
    por_sequence(10);
    @(negedge clk);
    soft_sequence(3);

    // Abort during S_SOFT with cnt == 3
    @(negedge clk);
    soft_rst_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    soft_rst_req = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_periph", periph_rst_n, 1'b0);
    check("abort_core", core_rst_n, 1'b0);
    check("abort_cause", rst_cause, 2'b01);
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    por_sequence(0);

    // Randomised requests and glitches checked by the model
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      soft_rst_req = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 199) == 0) begin
        #1 rst_n = 1'b0;
        #($urandom_range(1, 3)) rst_n = 1'b1;
      end
    end
    @(negedge clk);
    soft_rst_req = 1'b0;
    repeat (40) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
